// File: rtl/bsg_small_fifo.sv
// Parametrised ready/valid-in, valid/yumi-out FIFO of els_p entries with a pointer-addressed register array.
// Optional occupancy port count_o is built when BSG_SMALL_FIFO_COUNT_EN is defined.
module bsg_small_fifo #(
    parameter int width_p = 16,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
`ifdef BSG_SMALL_FIFO_COUNT_EN
    ,
    output logic [$clog2(els_p+1)-1:0] count_o
`endif
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    typedef logic [ptr_w_lp-1:0] ptr_t;
    typedef logic [cnt_w_lp-1:0] cnt_t;

    localparam ptr_t last_ptr_lp = ptr_t'(els_p - 1);
    localparam cnt_t full_cnt_lp = cnt_t'(els_p);

    // Wrap by explicit compare so non-power-of-two depths never index past the array.
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t n;
        if (p == last_ptr_lp) begin
            n = '0;
        end else begin
            n = p + ptr_t'(1);
        end
        return n;
    endfunction

    logic [width_p-1:0] mem_r [els_p];
    ptr_t               wptr_r;
    ptr_t               rptr_r;
    cnt_t               count_r;
    logic               v_r;
    logic               ready_r;

    logic               enq_s;
    logic               deq_s;
    cnt_t               count_nxt_s;

    // Handshake qualification and next occupancy; status flags gate both strobes.
    always_comb begin
        enq_s       = v_i & ready_r;
        deq_s       = yumi_i & v_r;
        count_nxt_s = count_r;
        case ({enq_s, deq_s})
            2'b10:   count_nxt_s = count_r + cnt_t'(1);
            2'b01:   count_nxt_s = count_r - cnt_t'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and the status flags registered from next occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            v_r     <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            if (enq_s) begin
                wptr_r <= ptr_inc(wptr_r);
            end
            if (deq_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            count_r <= count_nxt_s;
            v_r     <= (count_nxt_s != cnt_t'(0));
            ready_r <= (count_nxt_s != full_cnt_lp);
        end
    end

    // Storage is not reset; only slots between the pointers are ever observed.
    always_ff @(posedge clk_i) begin
        if (enq_s && !reset_i) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    assign v_o     = v_r;
    assign ready_o = ready_r;
    assign data_o  = mem_r[rptr_r];

`ifdef BSG_SMALL_FIFO_COUNT_EN
    assign count_o = count_r;
`endif

endmodule

// File: tb/tb_bsg_small_fifo.sv
// Directed and randomised checks of bsg_small_fifo at several depths against hand values and a ring-buffer model.
module tb_bsg_small_fifo;

    localparam int NI = 5;
    localparam int W  = 16;
    localparam int ELS [NI] = '{4, 3, 2, 5, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a   [NI];
    logic         v_a     [NI];
    logic         yumi_a  [NI];
    logic         ready_a [NI];
    logic         vo_a    [NI];
    logic [W-1:0] din_a   [NI];
    logic [W-1:0] dout_a  [NI];
`ifdef BSG_SMALL_FIFO_COUNT_EN
    logic [3:0]   cnt_a   [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
`ifdef BSG_SMALL_FIFO_COUNT_EN
        logic [$clog2(ELS[g]+1)-1:0] cnt_w;
        assign cnt_a[g] = 4'(cnt_w);
`endif
        bsg_small_fifo #(.width_p(W), .els_p(ELS[g])) dut (
            .clk_i   (clk),
            .reset_i (rst_a[g]),
            .v_i     (v_a[g]),
            .data_i  (din_a[g]),
            .ready_o (ready_a[g]),
            .v_o     (vo_a[g]),
            .data_o  (dout_a[g]),
            .yumi_i  (yumi_a[g])
`ifdef BSG_SMALL_FIFO_COUNT_EN
            ,
            .count_o (cnt_w)
`endif
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Occupancy check; without the count port, occupancy is only visible through v_o.
    task automatic chk_cnt(input string tag, input int g, input int exp);
`ifdef BSG_SMALL_FIFO_COUNT_EN
        check(tag, 32'(cnt_a[g]), 32'(exp));
`else
        check(tag, 32'(vo_a[g]), 32'(exp != 0));
`endif
    endtask

    task automatic step(input int g, input logic v, input logic [W-1:0] d, input logic y);
        v_a[g]    = v;
        din_a[g]  = d;
        yumi_a[g] = y;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] mq [NI][8];
    int mh [NI];
    int mt [NI];
    int mc [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_a[i]  = 1'b1;
            v_a[i]    = 1'b0;
            yumi_a[i] = 1'b0;
            din_a[i]  = '0;
            mh[i] = 0; mt[i] = 0; mc[i] = 0;
        end

        // reset held two cycles with v_i asserted
        v_a[0]   = 1'b1;
        din_a[0] = 16'hDEAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_v", 32'(vo_a[0]), 32'd0);
        check("rst_ready", 32'(ready_a[0]), 32'd1);
        chk_cnt("rst_cnt", 0, 0);
        for (int i = 0; i < NI; i++) rst_a[i] = 1'b0;
        step(0, 1'b0, 16'h0000, 1'b0);
        check("rst_nothing_enq", 32'(vo_a[0]), 32'd0);

        // fill, overfill, drain
        for (int i = 1; i <= 4; i++) begin
            step(0, 1'b1, 16'(i), 1'b0);
            check("fill_v", 32'(vo_a[0]), 32'd1);
            check("fill_head", 32'(dout_a[0]), 32'h0001);
            check("fill_ready", 32'(ready_a[0]), 32'(i < 4));
            chk_cnt("fill_cnt", 0, i);
        end
        step(0, 1'b1, 16'h0005, 1'b0);
        check("full_drop_ready", 32'(ready_a[0]), 32'd0);
        check("full_drop_head", 32'(dout_a[0]), 32'h0001);
        chk_cnt("full_drop_cnt", 0, 4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(dout_a[0]), 32'(i));
            step(0, 1'b0, 16'h0000, 1'b1);
            chk_cnt("drain_cnt", 0, 4 - i);
        end
        check("drain_empty_v", 32'(vo_a[0]), 32'd0);
        check("drain_empty_ready", 32'(ready_a[0]), 32'd1);

        // full plus yumi: no same-cycle enqueue, slot offered next cycle
        for (int i = 0; i < 4; i++) step(0, 1'b1, 16'(16'h0011 + i), 1'b0);
        check("fy_full", 32'(ready_a[0]), 32'd0);
        step(0, 1'b1, 16'h0015, 1'b1);
        check("fy_ready_after", 32'(ready_a[0]), 32'd1);
        chk_cnt("fy_cnt3", 0, 3);
        check("fy_head", 32'(dout_a[0]), 32'h0012);
        step(0, 1'b1, 16'h0015, 1'b0);
        chk_cnt("fy_cnt4", 0, 4);
        check("fy_full_again", 32'(ready_a[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("fy_order", 32'(dout_a[0]), 32'(16'h0012 + i));
            step(0, 1'b0, 16'h0000, 1'b1);
        end
        check("fy_empty", 32'(vo_a[0]), 32'd0);

        // yumi while empty is masked
        step(0, 1'b0, 16'h0000, 1'b1);
        step(0, 1'b0, 16'h0000, 1'b1);
        check("ill_v", 32'(vo_a[0]), 32'd0);
        check("ill_ready", 32'(ready_a[0]), 32'd1);
        chk_cnt("ill_cnt", 0, 0);
        step(0, 1'b1, 16'h0021, 1'b0);
        check("ill_head", 32'(dout_a[0]), 32'h0021);
        chk_cnt("ill_cnt1", 0, 1);
        step(0, 1'b1, 16'h0022, 1'b0);
        chk_cnt("ill_cnt2", 0, 2);

        // mid-operation reset with v_i high
        rst_a[0] = 1'b1;
        step(0, 1'b1, 16'h0099, 1'b0);
        rst_a[0] = 1'b0;
        check("mrst_v", 32'(vo_a[0]), 32'd0);
        check("mrst_ready", 32'(ready_a[0]), 32'd1);
        chk_cnt("mrst_cnt", 0, 0);
        step(0, 1'b1, 16'h0031, 1'b0);
        check("mrst_head", 32'(dout_a[0]), 32'h0031);
        chk_cnt("mrst_cnt1", 0, 1);
        step(0, 1'b0, 16'h0000, 1'b1);
        check("mrst_empty", 32'(vo_a[0]), 32'd0);

        // streaming through a depth-3 FIFO with one entry primed
        step(1, 1'b1, 16'h0A00, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            check("stream_data", 32'(dout_a[1]), 32'(16'h0A00 + i - 1));
            step(1, 1'b1, 16'(16'h0A00 + i), 1'b1);
            chk_cnt("stream_cnt", 1, 1);
            check("stream_ready", 32'(ready_a[1]), 32'd1);
        end
        check("stream_last", 32'(dout_a[1]), 32'h0A0A);
        step(1, 1'b0, 16'h0000, 1'b1);
        check("stream_empty", 32'(vo_a[1]), 32'd0);

        // random traffic on depths 2, 5 and 8 against a ring-buffer model
        for (int c = 0; c < 10000; c++) begin
            for (int g = 2; g < NI; g++) begin
                logic enq;
                logic deq;
                check("rnd_v", 32'(vo_a[g]), 32'(mc[g] != 0));
                check("rnd_ready", 32'(ready_a[g]), 32'(mc[g] != ELS[g]));
                chk_cnt("rnd_cnt", g, mc[g]);
                if (mc[g] != 0) begin
                    check("rnd_data", 32'(dout_a[g]), 32'(mq[g][mh[g]]));
                end
                v_a[g]   = 1'($urandom);
                din_a[g] = 16'($urandom);
                if (((c / 500) % 2) == 0) begin
                    yumi_a[g] = (mc[g] != 0) && ($urandom_range(0, 3) == 0);
                end else begin
                    yumi_a[g] = (mc[g] != 0) && ($urandom_range(0, 3) != 0);
                end
                enq = v_a[g] && (mc[g] != ELS[g]);
                deq = yumi_a[g];
                if (deq) begin
                    mh[g] = (mh[g] + 1) % ELS[g];
                    mc[g] = mc[g] - 1;
                end
                if (enq) begin
                    mq[g][mt[g]] = din_a[g];
                    mt[g] = (mt[g] + 1) % ELS[g];
                    mc[g] = mc[g] + 1;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
